// File: rtl/csr_pkg.sv
// Shared Zicsr encodings, implemented CSR map and FSM state type for the CSR access unit.
package csr_pkg;

   typedef enum logic [2:0] {
      F3_RSV0 = 3'b000,
      CSRRW   = 3'b001,
      CSRRS   = 3'b010,
      CSRRC   = 3'b011,
      F3_RSV4 = 3'b100,
      CSRRWI  = 3'b101,
      CSRRSI  = 3'b110,
      CSRRCI  = 3'b111
   } funct3_t;

   localparam logic [11:0] CSR_ALUCSR    = 12'h800;
   localparam logic [11:0] CSR_MULCSR    = 12'h801;
   localparam logic [11:0] CSR_DIVCSR    = 12'h802;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   function automatic logic csr_is_writable(input logic [11:0] idx);
      return (idx == CSR_ALUCSR) || (idx == CSR_MULCSR) || (idx == CSR_DIVCSR);
   endfunction

   function automatic logic csr_is_read_only(input logic [11:0] idx);
      return (idx == CSR_MCYCLE) || (idx == CSR_MINSTRET) ||
             (idx == CSR_MCYCLEH) || (idx == CSR_MINSTRETH);
   endfunction

endpackage

// File: rtl/csr_access_decode.sv
// Combinational Zicsr decode: read suppression, write intent, legality and the new CSR value.
module csr_access_decode
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3,
   input  logic [11:0]     csr_index,
   input  logic [4:0]      rs1_index,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [4:0]      rd_index,
   input  logic [XLEN-1:0] read_data,
   output logic            read_suppress,
   output logic            do_write,
   output logic            illegal,
   output logic [XLEN-1:0] old_value,
   output logic [XLEN-1:0] new_value
);

   logic [XLEN-1:0] operand;
   logic            bad_funct3;

   always_comb begin
      // Immediate forms reuse the rs1 field as a zero-extended 5-bit zimm.
      operand       = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_index} : rs1_data;
      read_suppress = ((funct3 == CSRRW) || (funct3 == CSRRWI)) && (rd_index == 5'd0);
      old_value     = read_suppress ? '0 : read_data;
      new_value     = '0;
      do_write      = 1'b1;
      bad_funct3    = 1'b0;

      case (funct3_t'(funct3))
         CSRRW, CSRRWI: begin
            new_value = operand;
         end
         CSRRS, CSRRSI: begin
            new_value = old_value | operand;
            do_write  = (rs1_index != 5'd0);
         end
         CSRRC, CSRRCI: begin
            new_value = old_value & ~operand;
            do_write  = (rs1_index != 5'd0);
         end
         default: begin
            bad_funct3 = 1'b1;
         end
      endcase

      illegal = bad_funct3 ||
                !(csr_is_writable(csr_index) || csr_is_read_only(csr_index)) ||
                (do_write && csr_is_read_only(csr_index));
   end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer between execute dispatch and the CSR file.
// Optional CSR_ILLEGAL_COUNT_EN adds a saturating count of illegal responses accepted by writeback.
module csr_access_unit
   import csr_pkg::*;
#(
   parameter int XLEN = 32
`ifdef CSR_ILLEGAL_COUNT_EN
   ,
   parameter int ILLEGAL_CNT_W = 16
`endif
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               req_funct3,
   input  logic [11:0]              req_csr_index,
   input  logic [4:0]               req_rs1_index,
   input  logic [XLEN-1:0]          req_rs1_data,
   input  logic [4:0]               req_rd_index,
   input  logic                     flush,
   output logic                     csr_read_enable,
   output logic [11:0]              csr_read_index,
   input  logic [XLEN-1:0]          csr_read_data,
   output logic                     csr_write_enable,
   output logic [11:0]              csr_write_index,
   output logic [XLEN-1:0]          csr_write_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [4:0]               rsp_rd_index,
   output logic [XLEN-1:0]          rsp_data,
   output logic                     rsp_illegal
`ifdef CSR_ILLEGAL_COUNT_EN
   ,
   output logic [ILLEGAL_CNT_W-1:0] illegal_count
`endif
);

   state_t          state_reg;
   logic [2:0]      funct3_reg;
   logic [11:0]     index_reg;
   logic [4:0]      rs1_index_reg;
   logic [XLEN-1:0] rs1_data_reg;
   logic [4:0]      rd_index_reg;
   logic [XLEN-1:0] old_reg;
   logic [XLEN-1:0] new_reg;
   logic            illegal_reg;

   logic            read_suppress;
   logic            do_write;
   logic            illegal;
   logic [XLEN-1:0] old_value;
   logic [XLEN-1:0] new_value;

   csr_access_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .funct3        (funct3_reg),
      .csr_index     (index_reg),
      .rs1_index     (rs1_index_reg),
      .rs1_data      (rs1_data_reg),
      .rd_index      (rd_index_reg),
      .read_data     (csr_read_data),
      .read_suppress (read_suppress),
      .do_write      (do_write),
      .illegal       (illegal),
      .old_value     (old_value),
      .new_value     (new_value)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         funct3_reg    <= '0;
         index_reg     <= '0;
         rs1_index_reg <= '0;
         rs1_data_reg  <= '0;
         rd_index_reg  <= '0;
         old_reg       <= '0;
         new_reg       <= '0;
         illegal_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // flush is deliberately ignored here so a same-cycle request is not lost.
               if (req_valid) begin
                  funct3_reg    <= req_funct3;
                  index_reg     <= req_csr_index;
                  rs1_index_reg <= req_rs1_index;
                  rs1_data_reg  <= req_rs1_data;
                  rd_index_reg  <= req_rd_index;
                  state_reg     <= READ;
               end
            end
            READ: begin
               if (flush) begin
                  state_reg <= IDLE;
               end else begin
                  old_reg     <= old_value;
                  new_reg     <= new_value;
                  illegal_reg <= illegal;
                  state_reg   <= (do_write && !illegal) ? WRITE : RESP;
               end
            end
            WRITE: begin
               // The write is already on the CSR port this cycle; flush only drops the response.
               state_reg <= flush ? IDLE : RESP;
            end
            RESP: begin
               if (flush || rsp_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef CSR_ILLEGAL_COUNT_EN
   logic [ILLEGAL_CNT_W-1:0] illegal_count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         illegal_count_reg <= '0;
      end else if ((state_reg == RESP) && rsp_ready && !flush && illegal_reg &&
                   (illegal_count_reg != {ILLEGAL_CNT_W{1'b1}})) begin
         illegal_count_reg <= illegal_count_reg + 1'b1;
      end
   end

   assign illegal_count = illegal_count_reg;
`endif

   // Every output is decoded from state and captured fields, never from req_* directly.
   always_comb begin
      req_ready        = (state_reg == IDLE);
      csr_read_enable  = (state_reg == READ) && !read_suppress;
      csr_read_index   = (state_reg == READ) ? index_reg : '0;
      csr_write_enable = (state_reg == WRITE);
      csr_write_index  = (state_reg == WRITE) ? index_reg : '0;
      csr_write_data   = (state_reg == WRITE) ? new_reg : '0;
      rsp_valid        = (state_reg == RESP);
      rsp_rd_index     = (state_reg == RESP) ? rd_index_reg : '0;
      rsp_data         = ((state_reg == RESP) && !illegal_reg) ? old_reg : '0;
      rsp_illegal      = (state_reg == RESP) && illegal_reg;
   end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed Zicsr cases plus randomized traffic
// against a reference model of the CSR map; also checks illegal_count when CSR_ILLEGAL_COUNT_EN is set.
module tb_csr_access_unit;

   localparam logic [31:0] MINSTRET_VAL  = 32'h0001_2345;
   localparam logic [31:0] MCYCLEH_VAL   = 32'h0000_0003;
   localparam logic [31:0] MINSTRETH_VAL = 32'h0000_0004;
   localparam logic [31:0] JUNK_VAL      = 32'hBAD0_BAD0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_funct3 = '0;
   logic [11:0] req_csr_index = '0;
   logic [4:0]  req_rs1_index = '0;
   logic [31:0] req_rs1_data = '0;
   logic [4:0]  req_rd_index = '0;
   logic        flush = 1'b0;
   logic        csr_read_enable;
   logic [11:0] csr_read_index;
   logic [31:0] csr_read_data;
   logic        csr_write_enable;
   logic [11:0] csr_write_index;
   logic [31:0] csr_write_data;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [4:0]  rsp_rd_index;
   logic [31:0] rsp_data;
   logic        rsp_illegal;
`ifdef CSR_ILLEGAL_COUNT_EN
   logic [15:0] illegal_count;
`endif

   int n_compared = 0;
   int n_mismatched = 0;
   int exp_illegal_count = 0;

   // CSR file seen by the DUT: writable entries plus a free-running cycle counter.
   logic [31:0] f_alu = '0;
   logic [31:0] f_mul = '0;
   logic [31:0] f_div = '0;
   logic [31:0] ctr = '0;

   // Reference contents of the writable CSRs, updated only from model-predicted writes.
   logic [31:0] ref_alu = '0;
   logic [31:0] ref_mul = '0;
   logic [31:0] ref_div = '0;

   csr_access_unit #(
      .XLEN (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_funct3       (req_funct3),
      .req_csr_index    (req_csr_index),
      .req_rs1_index    (req_rs1_index),
      .req_rs1_data     (req_rs1_data),
      .req_rd_index     (req_rd_index),
      .flush            (flush),
      .csr_read_enable  (csr_read_enable),
      .csr_read_index   (csr_read_index),
      .csr_read_data    (csr_read_data),
      .csr_write_enable (csr_write_enable),
      .csr_write_index  (csr_write_index),
      .csr_write_data   (csr_write_data),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_rd_index     (rsp_rd_index),
      .rsp_data         (rsp_data),
      .rsp_illegal      (rsp_illegal)
`ifdef CSR_ILLEGAL_COUNT_EN
      ,
      .illegal_count    (illegal_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ctr <= ctr + 32'd1;
      if (csr_write_enable) begin
         case (csr_write_index)
            12'h800: f_alu <= csr_write_data;
            12'h801: f_mul <= csr_write_data;
            12'h802: f_div <= csr_write_data;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (csr_read_index)
         12'h800: csr_read_data = f_alu;
         12'h801: csr_read_data = f_mul;
         12'h802: csr_read_data = f_div;
         12'hB00: csr_read_data = ctr;
         12'hB02: csr_read_data = MINSTRET_VAL;
         12'hB80: csr_read_data = MCYCLEH_VAL;
         12'hB82: csr_read_data = MINSTRETH_VAL;
         default: csr_read_data = JUNK_VAL;
      endcase
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic ref_writable(input logic [11:0] idx);
      return (idx == 12'h800) || (idx == 12'h801) || (idx == 12'h802);
   endfunction

   function automatic logic ref_read_only(input logic [11:0] idx);
      return (idx == 12'hB00) || (idx == 12'hB02) || (idx == 12'hB80) || (idx == 12'hB82);
   endfunction

   function automatic logic [31:0] ref_value(input logic [11:0] idx);
      case (idx)
         12'h800: return ref_alu;
         12'h801: return ref_mul;
         12'h802: return ref_div;
         12'hB00: return ctr;
         12'hB02: return MINSTRET_VAL;
         12'hB80: return MCYCLEH_VAL;
         12'hB82: return MINSTRETH_VAL;
         default: return 32'd0;
      endcase
   endfunction

   task automatic ref_store(input logic [11:0] idx, input logic [31:0] val);
      case (idx)
         12'h800: ref_alu = val;
         12'h801: ref_mul = val;
         12'h802: ref_div = val;
         default: ;
      endcase
   endtask

   // flush_at: 0 none, 1 during READ, 2 during the cycle after READ, 3 together with req_valid in IDLE.
   task automatic run_txn(input logic [2:0] f3, input logic [11:0] idx, input logic [4:0] rs1,
                          input logic [31:0] d, input logic [4:0] rd, input int flush_at, input int hold);
      logic [31:0] operand, old_v, new_v, wr_d;
      logic [11:0] wr_i;
      logic        bad_op, suppress, writes, ill, exp_wr, exp_wr_eff, is_flush;
      int          wr_seen, wr_cyc, rsp_cyc, late_rsp, h;
      bit          done;

      bad_op   = (f3 == 3'd0) || (f3 == 3'd4);
      operand  = f3[2] ? {27'd0, rs1} : d;
      suppress = ((f3 == 3'd1) || (f3 == 3'd5)) && (rd == 5'd0);
      if (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) writes = (rs1 != 5'd0);
      else writes = 1'b1;
      ill      = bad_op || !(ref_writable(idx) || ref_read_only(idx)) || (writes && ref_read_only(idx));
      exp_wr   = writes && !ill;
      is_flush = (flush_at == 1) || (flush_at == 2);

      @(negedge clk);
      check("req_ready_idle", req_ready, 1'b1);
      req_funct3    = f3;
      req_csr_index = idx;
      req_rs1_index = rs1;
      req_rs1_data  = d;
      req_rd_index  = rd;
      req_valid     = 1'b1;
      flush         = (flush_at == 3);
      @(posedge clk);
      #1;
      req_valid     = 1'b0;
      flush         = 1'b0;
      req_funct3    = 3'($urandom);
      req_csr_index = 12'($urandom);
      req_rs1_index = 5'($urandom);
      req_rs1_data  = $urandom;
      req_rd_index  = 5'($urandom);

      @(negedge clk);
      check("read_enable", csr_read_enable, !suppress);
      check("read_index", csr_read_index, idx);
      old_v = suppress ? 32'd0 : ref_value(idx);
      case (f3)
         3'd1, 3'd5: new_v = operand;
         3'd2, 3'd6: new_v = old_v | operand;
         3'd3, 3'd7: new_v = old_v & ~operand;
         default:    new_v = 32'd0;
      endcase
      if (flush_at == 1) flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;

      wr_seen = 0; wr_cyc = 0; wr_d = '0; wr_i = '0;
      rsp_cyc = 0; late_rsp = 0; h = 0; done = 0;
      for (int k = 2; k <= 14 && !done; k++) begin
         @(negedge clk);
         if (csr_write_enable) begin
            wr_seen++;
            wr_cyc = k;
            wr_d   = csr_write_data;
            wr_i   = csr_write_index;
         end
         if (is_flush) begin
            if (rsp_valid && (k >= ((flush_at == 1) ? 2 : 3))) late_rsp++;
            if (flush_at == 2 && k == 2) begin
               flush = 1'b1;
               @(posedge clk);
               #1 flush = 1'b0;
            end
            if (k >= 5) done = 1;
         end else if (rsp_valid) begin
            if (rsp_cyc == 0) begin
               rsp_cyc = k;
               check("rsp_cycle", k, exp_wr ? 3 : 2);
            end else begin
               check("hold_req_ready", req_ready, 1'b0);
            end
            check("rsp_data", rsp_data, ill ? 32'd0 : old_v);
            check("rsp_rd", rsp_rd_index, rd);
            check("rsp_illegal", rsp_illegal, ill);
            if (h == hold) begin
               rsp_ready = 1'b1;
               @(posedge clk);
               #1 rsp_ready = 1'b0;
               done = 1;
               if (ill) exp_illegal_count++;
            end else begin
               h++;
            end
         end
      end
      if (!is_flush && !done) check("rsp_timeout", 32'd0, 32'd1);
      if (is_flush) check("no_rsp_after_flush", late_rsp, 0);

      exp_wr_eff = exp_wr && (flush_at != 1);
      check("write_count", wr_seen, exp_wr_eff ? 1 : 0);
      if (exp_wr_eff && wr_seen == 1) begin
         check("write_cycle", wr_cyc, 2);
         check("write_index", wr_i, idx);
         check("write_data", wr_d, new_v);
      end
      if (exp_wr_eff) ref_store(idx, new_v);

      @(negedge clk);
      check("file_alu", f_alu, ref_alu);
      check("file_mul", f_mul, ref_mul);
      check("file_div", f_div, ref_div);
      $display("txn f3=%0d idx=%h rs1=%0d data=%h rd=%0d flush=%0d hold=%0d -> write=%0d illegal=%0d old=%h new=%h",
               f3, idx, rs1, d, rd, flush_at, hold, exp_wr_eff, ill, old_v, new_v);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req_ready"}, req_ready, 1'b1);
      check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check({tag, "_rsp_data"}, rsp_data, 32'd0);
      check({tag, "_rsp_illegal"}, rsp_illegal, 1'b0);
      check({tag, "_read_enable"}, csr_read_enable, 1'b0);
      check({tag, "_write_enable"}, csr_write_enable, 1'b0);
      check({tag, "_read_index"}, csr_read_index, 12'd0);
   endtask

   initial begin
      logic [11:0] idx_pool [10];
      logic [4:0]  rs1_r, rd_r;
      int          r, fl;

      idx_pool = '{12'h800, 12'h801, 12'h802, 12'hB00, 12'hB02,
                   12'hB80, 12'hB82, 12'h803, 12'h300, 12'hC00};

      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
`ifdef CSR_ILLEGAL_COUNT_EN
      check("reset_illegal_count", illegal_count, 16'd0);
`endif

      // Directed cases.
      run_txn(3'd1, 12'h801, 5'd1, 32'h0000_0012, 5'd0, 0, 0);   // MULCSR := 0x12, read suppressed
      run_txn(3'd1, 12'h801, 5'd1, 32'hDEAD_BEEF, 5'd5, 0, 0);   // CSRRW x5
      run_txn(3'd2, 12'hB00, 5'd0, 32'hFFFF_FFFF, 5'd7, 0, 0);   // read mcycle
      run_txn(3'd5, 12'hB02, 5'd3, 32'd0, 5'd4, 0, 0);           // CSRRWI to read-only
      run_txn(3'd4, 12'h800, 5'd9, 32'h1234_5678, 5'd6, 0, 0);   // reserved funct3
      run_txn(3'd1, 12'h800, 5'd1, 32'h0000_00FF, 5'd0, 0, 0);   // ALUCSR := 0xFF
      run_txn(3'd7, 12'h800, 5'h1F, 32'h0, 5'd0, 0, 5);          // CSRRCI, held response
      run_txn(3'd1, 12'h802, 5'd2, 32'hCAFE_F00D, 5'd1, 1, 0);   // flush in READ
      run_txn(3'd1, 12'h802, 5'd2, 32'h0BAD_CAFE, 5'd1, 2, 0);   // flush in WRITE
      run_txn(3'd2, 12'h802, 5'd4, 32'h0000_F000, 5'd8, 3, 1);   // flush alongside req in IDLE
      run_txn(3'd3, 12'h803, 5'd1, 32'h1, 5'd2, 0, 0);           // unimplemented index

      for (int i = 0; i < 40; i++) begin
         r     = $urandom_range(0, 9);
         fl    = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
         rs1_r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         rd_r  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         run_txn(3'($urandom_range(0, 7)), idx_pool[$urandom_range(0, 9)], rs1_r, $urandom,
                 rd_r, fl, $urandom_range(0, 3));
      end

`ifdef CSR_ILLEGAL_COUNT_EN
      check("illegal_count", illegal_count, exp_illegal_count);
`endif

      // Asynchronous reset while the write is on the port.
      @(negedge clk);
      req_funct3    = 3'd1;
      req_csr_index = 12'h800;
      req_rs1_index = 5'd1;
      req_rs1_data  = 32'hA5A5_A5A5;
      req_rd_index  = 5'd2;
      req_valid     = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("write_before_reset", csr_write_enable, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("write_after_reset", csr_write_enable, 1'b0);
      check("rsp_after_reset", rsp_valid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");
      check("reset_no_write_alu", f_alu, ref_alu);
`ifdef CSR_ILLEGAL_COUNT_EN
      check("post_reset_illegal_count", illegal_count, 16'd0);
`endif
      run_txn(3'd2, 12'h800, 5'd0, 32'd0, 5'd3, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
